// File: rtl/kbd_link_pkg.sv
// Shared definitions for the host-to-keyboard serial link: frame geometry,
// command addresses understood by the keyboard CPLD, and the link FSM states.
package kbd_link_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_PAD   = 5;

    localparam logic [2:0] FIFO_CTRL = 3'd1;
    localparam logic [2:0] LCD_CMD   = 3'd2;
    localparam logic [2:0] LCD_DATA  = 3'd3;
    localparam logic [2:0] CTRL_REG  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } link_state_e;

endpackage

// File: rtl/spi_half_tick.sv
// SCK half-period divider: counts 0..CLK_DIV-1 while enabled and pulses tick
// on the terminal count. Cleared whenever the link FSM changes state.
module spi_half_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || !en || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_kbd_host.sv
// SPI mode-0 master for the keyboard CPLD: sends {pad, addr, data} MSB first
// and captures the event byte returned during the second half of the frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | sel high, waiting for start
// ST_SETUP | sel low, bit 15 presented on sdo, CLK_DIV cycles
// ST_SHIFT | 16 bits, each CLK_DIV low then CLK_DIV high
// ST_HOLD  | sel low, sck low after the last bit, CLK_DIV cycles
// ST_GAP   | sel high for GAP cycles, then done pulse and return to idle
module spi_kbd_host
    import kbd_link_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 2,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int REPLY_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  cmdAddr,
    input  logic [DATA_W-1:0]  cmdData,
    output logic               busy,
    output logic               done,
    output logic [REPLY_W-1:0] reply,
    output logic               sel,
    output logic               sck,
    output logic               sdo,
    input  logic               sdi
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [3:0]    BIT_LAST = 4'(FRAME_BITS - 1);

    link_state_e state_q, state_d;

    logic                  tick;
    logic                  sck_q;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] tx_sh;
    logic [REPLY_W-1:0]    rx_sh;
    logic [GW-1:0]         gap_cnt;
    logic [FRAME_BITS-1:0] frame;

    logic accept, sample, shift, gap_load, finish;

    assign frame = {{(FRAME_BITS - ADDR_W - DATA_W){1'b0}}, cmdAddr, cmdData};

    spi_half_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_half_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .clr  (state_d != state_q),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        sample   = 1'b0;
        shift    = 1'b0;
        gap_load = 1'b0;
        finish   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // tick at the end of a low half raises sck; at the end of a high half it drops it
                if (tick) begin
                    if (!sck_q) begin
                        sample = 1'b1;
                    end else begin
                        shift = 1'b1;
                        if (bit_cnt == 4'd0) state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    gap_load = 1'b1;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sck_q   <= 1'b0;
            bit_cnt <= 4'd0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            gap_cnt <= '0;
            reply   <= '0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                tx_sh   <= frame;
                bit_cnt <= BIT_LAST;
            end
            if (sample) begin
                sck_q <= 1'b1;
                rx_sh <= {rx_sh[REPLY_W-2:0], sdi};
            end
            if (shift) begin
                sck_q   <= 1'b0;
                tx_sh   <= {tx_sh[FRAME_BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt - 1'b1;
            end
            if (gap_load) begin
                gap_cnt <= GAP_LAST;
            end else if ((state_q == ST_GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            // only the last REPLY_W samples survive in rx_sh, i.e. the second byte
            if (finish) reply <= rx_sh;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign sel  = (state_q == ST_IDLE) || (state_q == ST_GAP);
    assign sck  = sck_q;
    assign sdo  = tx_sh[FRAME_BITS-1];

endmodule

// File: tb/tb_spi_kbd_host.sv
// Scoreboard bench for spi_kbd_host: three instances (CLK_DIV/GAP = 4/2, 1/2, 1/1),
// each with a keyboard-side slave model and a done-driven monitor.
module tb_spi_kbd_host;

    typedef struct {
        logic [7:0]  reply;
        int          done_cyc;
        logic [15:0] frame;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_pass  = 0;
    int n_total = 0;

    exp_t exp_q[3][$];

    logic       rst[3];
    logic       start[3];
    logic [2:0] addr[3];
    logic [7:0] data[3];
    logic       loop[3];
    logic [7:0] slave_byte[3];
    logic       busy[3];
    logic       done[3];
    logic [7:0] reply[3];
    logic       sel[3];
    logic       sck[3];
    logic       sdo[3];

    function automatic int cd_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int gp_of(input int d);
        return (d == 2) ? 1 : 2;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, req, cyc);
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int CD = (g == 0) ? 4 : 1;
        localparam int GP = (g == 2) ? 1 : 2;

        int          srise = 0;
        logic        sdi_w;
        int          rises = 0;
        logic [15:0] cap = '0;
        logic        sck_prev = 1'b0;
        exp_t        e;

        // keyboard side: first byte is filler (all ones), second byte is the event
        always @(posedge sck[g] or posedge sel[g]) begin
            if (sel[g]) srise <= 0;
            else        srise <= srise + 1;
        end

        always_comb begin
            if (loop[g])                         sdi_w = sdo[g];
            else if (srise >= 8 && srise <= 15)  sdi_w = slave_byte[g][3'(15 - srise)];
            else                                 sdi_w = 1'b1;
        end

        spi_kbd_host #(
            .CLK_DIV(CD), .GAP(GP), .ADDR_W(3), .DATA_W(8), .REPLY_W(8)
        ) u_dut (
            .clk(clk), .rst(rst[g]), .start(start[g]), .cmdAddr(addr[g]), .cmdData(data[g]),
            .busy(busy[g]), .done(done[g]), .reply(reply[g]), .sel(sel[g]), .sck(sck[g]),
            .sdo(sdo[g]), .sdi(sdi_w)
        );

        always @(negedge clk) begin
            if (!rst[g]) begin
                rises = 0;
                cap = '0;
                sck_prev = 1'b0;
            end else begin
                if (!sel[g] && sck[g] && !sck_prev) begin
                    rises++;
                    cap = {cap[14:0], sdo[g]};
                end
                sck_prev = sck[g];
                if (done[g]) begin
                    if (exp_q[g].size() == 0) begin
                        n_total++;
                        $display("FAIL dut%0d unexpected_done: got done at cycle %0d, required none", g, cyc);
                    end else begin
                        e = exp_q[g].pop_front();
                        chk($sformatf("dut%0d reply", g), int'(reply[g]), int'(e.reply));
                        chk($sformatf("dut%0d done_cycle", g), cyc, e.done_cyc);
                        chk($sformatf("dut%0d sdo_frame", g), int'(cap), int'(e.frame));
                        chk($sformatf("dut%0d sck_rises", g), rises, 16);
                        chk($sformatf("dut%0d busy_at_done", g), int'(busy[g]), 0);
                    end
                    rises = 0;
                    cap = '0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic push_exp(input int d, input logic [7:0] rep, input int acc,
                            input logic [2:0] a, input logic [7:0] dt);
        exp_t x;
        x.reply    = rep;
        x.done_cyc = acc + 34 * cd_of(d) + gp_of(d);
        x.frame    = {5'b0, a, dt};
        exp_q[d].push_back(x);
    endtask

    task automatic issue(input int d, input logic [2:0] a, input logic [7:0] dt,
                         input logic [7:0] rep, output int acc);
        int budget = 0;
        while (busy[d] && budget < 400) begin
            step();
            budget++;
        end
        if (busy[d]) begin
            n_total++;
            $display("FAIL dut%0d idle_timeout: got busy=1 after %0d cycles, required busy=0", d, budget);
        end
        addr[d]  = a;
        data[d]  = dt;
        start[d] = 1'b1;
        acc = cyc + 1;
        push_exp(d, rep, acc, a, dt);
        step();
        start[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int budget = 0;
        while (exp_q[d].size() != 0 && budget < 400) begin
            step();
            budget++;
        end
        if (exp_q[d].size() != 0) begin
            n_total++;
            $display("FAIL dut%0d done_timeout: got %0d frames pending, required 0", d, exp_q[d].size());
            exp_q[d].delete();
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a1, a2, n_sel, n_idle;
        bit toggles_ok;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0;
            start[i] = 1'b0;
            addr[i] = 3'd0;
            data[i] = 8'd0;
            loop[i] = 1'b0;
            slave_byte[i] = 8'd0;
        end
        repeat (3) step();
        for (int i = 0; i < 3; i++) rst[i] = 1'b1;
        step();

        chk("reset sel", int'(sel[0]), 1);
        chk("reset sck", int'(sck[0]), 0);
        chk("reset sdo", int'(sdo[0]), 0);
        chk("reset busy", int'(busy[0]), 0);
        chk("reset done", int'(done[0]), 0);
        chk("reset reply", int'(reply[0]), 0);

        // loopback, FIFO clear with zero data
        loop[0] = 1'b1;
        issue(0, kbd_link_pkg::FIFO_CTRL, 8'h00, 8'h00, a);
        chk("accept busy", int'(busy[0]), 1);
        chk("accept sel", int'(sel[0]), 0);
        drain(0);

        // slave returns 0xA5 in the second byte
        loop[0] = 1'b0;
        slave_byte[0] = 8'hA5;
        issue(0, kbd_link_pkg::CTRL_REG, 8'h0F, 8'hA5, a);
        drain(0);

        // start while busy is ignored
        slave_byte[0] = 8'h5A;
        issue(0, kbd_link_pkg::LCD_DATA, 8'h3E, 8'h5A, a);
        wait_until(a + 50);
        addr[0] = 3'd7;
        data[0] = 8'hFF;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        drain(0);
        wait_until(a + 220);
        chk("ignored_start idle", int'(busy[0]), 0);

        // reset mid-frame abandons the frame
        slave_byte[0] = 8'h99;
        issue(0, kbd_link_pkg::LCD_CMD, 8'h55, 8'h99, a);
        wait_until(a + 40);
        rst[0] = 1'b0;
        void'(exp_q[0].pop_back());
        step();
        rst[0] = 1'b1;
        chk("midreset sel", int'(sel[0]), 1);
        chk("midreset sck", int'(sck[0]), 0);
        chk("midreset busy", int'(busy[0]), 0);
        chk("midreset reply", int'(reply[0]), 0);
        wait_until(a + 200);
        issue(0, kbd_link_pkg::CTRL_REG, 8'hC0, 8'h99, a);
        drain(0);

        // back-to-back with start held high, CLK_DIV=1 GAP=2
        slave_byte[1] = 8'h3C;
        addr[1] = kbd_link_pkg::CTRL_REG;
        data[1] = 8'h81;
        start[1] = 1'b1;
        a1 = cyc + 1;
        a2 = a1 + 37;
        push_exp(1, 8'h3C, a1, kbd_link_pkg::CTRL_REG, 8'h81);
        wait_until(a1 + 10);
        addr[1] = kbd_link_pkg::LCD_DATA;
        data[1] = 8'h42;
        n_sel = 0;
        n_idle = 0;
        for (int c = a1 + 30; c <= a2 + 5; c++) begin
            wait_until(c);
            if (c == a1 + 36) begin
                slave_byte[1] = 8'hC3;
                push_exp(1, 8'hC3, a2, kbd_link_pkg::LCD_DATA, 8'h42);
            end
            if (sel[1]) n_sel++;
            if (!busy[1]) n_idle++;
        end
        start[1] = 1'b0;
        chk("b2b sel_high_cycles", n_sel, 3);
        chk("b2b busy_low_cycles", n_idle, 1);
        drain(1);

        // CLK_DIV=1 GAP=1 loopback of 0xFF: sck toggles every cycle
        loop[2] = 1'b1;
        issue(2, kbd_link_pkg::FIFO_CTRL, 8'hFF, 8'hFF, a);
        toggles_ok = 1'b1;
        for (int c = a + 1; c <= a + 32; c++) begin
            wait_until(c);
            if (sck[2] != logic'((c - a - 1) % 2)) toggles_ok = 1'b0;
        end
        chk("div1 sck_toggle", int'(toggles_ok), 1);
        drain(2);

        repeat (5) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
